spi_serf_regs: RTL
==================

Name: spi_serf_regs

Overview:
SPI responder (serf) for the 16-bit SPI_mnrch monarch. Runs on the system clock and oversamples SS_n/SCLK/MOSI. Exposes a small register bank: a WHO_AM_I ID, an interrupt control register, and four 16-bit sample channels loaded from a host-side port. Drives INT on data-ready. Serves as a synthesizable stand-in for the inertial sensor on the far end of the SPI bus.

Parameters:
WHO_AM_I, 8'h6A, constant returned at address 0x0F
SYNC_STAGES, 2, flops in each input synchronizer before edge detect (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  serf select from monarch, active low
SCLK  in  1  serial clock, idles high; monarch drives MOSI on fall, samples MISO on rise
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first; high-Z while SS_n high
INT  out  1  data-ready interrupt, active high
smpl_vld  in  1  one-clk pulse: latch smpl_data
smpl_data  in  64  ch3..ch0 samples, 16 b each, ch0 in [15:0]

Behaviour:
- Input sync: SS_n, SCLK and MOSI each pass through SYNC_STAGES flops plus one edge-detect flop. SCLK period must be ≥8 clk. SCLK and SS_n edges act on the synchronized versions.
- Frame format: 16 bits. Bit15 is R/W (1 = read), [14:8] is addr, [7:0] is write data (don't-care on read).
- FSM states:
  - IDLE: wait for SS_n fall, then clear bit_cnt and tx_shft and go to CMD.
  - CMD: shift MOSI into rx_shft[0] on each SCLK rise. On the 8th rise, look up addr and set tx_shft[15:8] to the read value, then go to DATA.
  - DATA: keep shifting on rises. On the 16th rise, go to DONE.
  - DONE: wait for SS_n rise, then commit and return to IDLE.
  - Any state: an SS_n rise before the 16th rise aborts the frame. Nothing is committed, no clear-on-read happens, return to IDLE.
- MISO = tx_shft[15] while SS_n is low. tx_shft shifts left (fill 0) on each SCLK fall after the 8th rise. Bits 15:8 seen by the monarch are 0; bits 7:0 carry the register value.
- Register map:
  - 0x0F: WHO_AM_I, read-only.
  - 0x0D: INT_CTRL, read/write, reset 0x00. Bit1 = INT enable; other bits are stored and read back.
  - 0x20–0x27: sample bytes, read-only. ch N low byte at 0x20+2N, high byte at 0x21+2N.
  - All other addresses read 0x00. Writes to read-only or unmapped addresses are ignored.
- Write commit: on SS_n rise in DONE with R/W = 0, write rx_shft[7:0] to addr.
- Sample load:
  - smpl_vld with SS_n high loads all four channels next clk and sets drdy.
  - smpl_vld with SS_n low is held pending, then applied on the frame-ending SS_n rise (completed or aborted frame).
  - Only the latest pending sample is kept. A frame never sees a torn sample.
- drdy is cleared when a completed read of 0x27 commits (SS_n rise). If a pending sample is applied on that same SS_n rise, the load wins and drdy stays 1.
- INT = drdy & INT_CTRL[1], registered.
- Reset (async): FSM IDLE, all registers 0, drdy 0, pending cleared, INT 0, MISO high-Z.

Optional Feature:
- Macro SPI_SERF_ABORT_CNT_EN.
- Defined: address 0x10 is a read-only 8-bit counter of aborted frames. It saturates at 0xFF and clears when a completed read of 0x10 commits. An abort in the same cycle as that commit leaves the counter at 1.
- Undefined: no counter logic is built and 0x10 reads 0x00.

Test Plan:
1. Monarch sends 16'h8F00 → rd_data[7:0] = 8'h6A, rd_data[15:8] = 8'h00, INT stays 0.
2. Write 16'h0D02, then smpl_vld with smpl_data = 64'h1234_5678_9ABC_DEF0 → INT rises within 2 clk. Then:
   - read 16'hA600 → 8'h34; INT still 1.
   - read 16'hA700 → 8'h12; INT falls after the SS_n rise.
3. Pulse smpl_vld (ch3 = 16'hAAAA) mid-frame during a read of 0x27 that holds old ch3 = 16'h1212 → frame returns 8'h12, new sample loads at SS_n rise, INT remains 1, next read of 0x27 returns 8'hAA.
4. Raise SS_n after 10 SCLK rises of a 16'h0D02 write → INT_CTRL stays 0x00. With SPI_SERF_ABORT_CNT_EN defined, 0x10 reads 0x01, then 0x00 on the next read.
5. Write 16'h0F55, then read 16'h8F00 → returns 8'h6A. Read 16'h9100 (unmapped) → returns 8'h00.
6. Assert rst_n low mid-frame, release, then run a full 16'h8F00 read → MISO high-Z while SS_n is high, INT = 0, read returns 8'h6A.

Source files
------------

// File: rtl/spi_serf_regs.sv
// spi_serf_regs: SPI responder (serf) on the system clock with a small register bank.
// It answers 16-bit frames {R/W, addr[6:0], data[7:0]} from a SPI monarch, serves a WHO_AM_I
// ID, an interrupt control register and four 16-bit sample channels, and raises INT on
// data-ready.
// Build option: define SPI_SERF_ABORT_CNT_EN to add a saturating aborted-frame counter,
// readable at address 0x10.
module spi_serf_regs #(
   parameter logic [7:0] WHO_AM_I    = 8'h6A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output wire logic   MISO,
   output logic        INT,
   input  logic        smpl_vld,
   input  logic [63:0] smpl_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [6:0] A_WHO   = 7'h0F;
   localparam logic [6:0] A_CTRL  = 7'h0D;
   localparam logic [6:0] A_ACNT  = 7'h10;
   localparam logic [6:0] A_CH3HI = 7'h27;

   // Pin synchronizers plus the edge-detect stage.
   logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
   logic                   ss_prev_q, sclk_prev_q, mosi_prev_q;
   logic                   ss_s, sclk_s, mosi_s;
   logic                   ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;

   // Frame state.
   logic [1:0]  state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] tx_q, tx_d;
   logic        commit_s, abort_s;

   // Register bank and sample handling.
   logic [7:0]  int_ctrl_q, int_ctrl_d;
   logic [63:0] samples_q, samples_d;
   logic [63:0] pend_data_q, pend_data_d;
   logic        pend_q, pend_d;
   logic        drdy_q, drdy_d;
   logic        int_q;
   logic        load_s;
   logic [63:0] load_data_s;
   logic [7:0]  abort_cnt_s;

   // Read-side address decode: returns the byte the monarch sees for a given address.
   function automatic logic [7:0] rd_mux(input logic [6:0]  a,
                                         input logic [7:0]  ctrl,
                                         input logic [63:0] smp,
                                         input logic [7:0]  acnt);
      logic [7:0] rd;
      case (a)
         A_WHO:   rd = WHO_AM_I;
         A_CTRL:  rd = ctrl;
         A_ACNT:  rd = acnt;
         default: begin
            if (a[6:3] == 4'b0100) begin
               rd = smp[{a[2:0], 3'b000} +: 8];
            end else begin
               rd = 8'h00;
            end
         end
      endcase
      return rd;
   endfunction

   // Bring SS_n/SCLK/MOSI into the clk domain; SS_n and SCLK rest high so reset matches idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_sync_q <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         ss_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
         mosi_prev_q <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         ss_prev_q   <= ss_s;
         sclk_prev_q <= sclk_s;
         mosi_prev_q <= mosi_sync_q[SYNC_STAGES-1];
      end
   end

   assign ss_s        = ss_sync_q[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_prev_q;
   assign ss_fall_s   = ss_prev_q & ~ss_s;
   assign ss_rise_s   = ~ss_prev_q & ss_s;
   assign sclk_rise_s = ~sclk_prev_q & sclk_s;
   assign sclk_fall_s = sclk_prev_q & ~sclk_s;

   // Frame sequencing: shift in on SCLK rises, load read data after the 8th rise, shift out on falls.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      commit_s  = 1'b0;
      abort_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_fall_s) begin
               bit_cnt_d = 5'd0;
               tx_d      = 16'h0000;
               state_d   = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (ss_rise_s) begin
               abort_s = 1'b1;
               state_d = ST_IDLE;
            end else if (sclk_rise_s) begin
               rx_d      = {rx_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd7) begin
                  tx_d    = {rd_mux({rx_q[5:0], mosi_s}, int_ctrl_q, samples_q, abort_cnt_s), 8'h00};
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_CMD;
               end
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_DATA: begin
            if (ss_rise_s) begin
               abort_s = 1'b1;
               state_d = ST_IDLE;
            end else if (sclk_rise_s) begin
               rx_d      = {rx_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd15) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DATA;
               end
            end else if (sclk_fall_s) begin
               // The fall right after the 8th rise must leave data bit 7 on MISO for rise 9.
               if (bit_cnt_q >= 5'd9) begin
                  tx_d = {tx_q[14:0], 1'b0};
               end else begin
                  tx_d = tx_q;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DONE: begin
            if (ss_rise_s) begin
               commit_s = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register writes, sample loading (direct when idle, deferred to frame end otherwise) and drdy.
   always_comb begin
      int_ctrl_d  = int_ctrl_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      load_s      = 1'b0;
      load_data_s = smpl_data;
      if (commit_s && !rx_q[15] && (rx_q[14:8] == A_CTRL)) begin
         int_ctrl_d = rx_q[7:0];
      end else begin
         int_ctrl_d = int_ctrl_q;
      end
      if (state_q == ST_IDLE) begin
         load_s = smpl_vld;
      end else if (commit_s || abort_s) begin
         pend_d = 1'b0;
         if (smpl_vld) begin
            load_s = 1'b1;
         end else begin
            load_s      = pend_q;
            load_data_s = pend_data_q;
         end
      end else if (smpl_vld) begin
         pend_d      = 1'b1;
         pend_data_d = smpl_data;
      end else begin
         pend_d = pend_q;
      end
      samples_d = load_s ? load_data_s : samples_q;
      if (load_s) begin
         drdy_d = 1'b1;
      end else if (commit_s && rx_q[15] && (rx_q[14:8] == A_CH3HI)) begin
         drdy_d = 1'b0;
      end else begin
         drdy_d = drdy_q;
      end
   end

`ifdef SPI_SERF_ABORT_CNT_EN
   logic [7:0] abort_cnt_q, abort_cnt_d;

   // Aborted-frame counter: saturates, cleared by a completed read of itself.
   always_comb begin
      if (commit_s && rx_q[15] && (rx_q[14:8] == A_ACNT)) begin
         abort_cnt_d = abort_s ? 8'd1 : 8'd0;
      end else if (abort_s && (abort_cnt_q != 8'hFF)) begin
         abort_cnt_d = abort_cnt_q + 8'd1;
      end else begin
         abort_cnt_d = abort_cnt_q;
      end
   end

   // Aborted-frame counter storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort_cnt_q <= 8'h00;
      end else begin
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign abort_cnt_s = abort_cnt_q;
`else
   assign abort_cnt_s = 8'h00;
`endif

   // State, shift registers, register bank and the registered interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 5'd0;
         rx_q        <= 16'h0000;
         tx_q        <= 16'h0000;
         int_ctrl_q  <= 8'h00;
         samples_q   <= 64'h0;
         pend_data_q <= 64'h0;
         pend_q      <= 1'b0;
         drdy_q      <= 1'b0;
         int_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         int_ctrl_q  <= int_ctrl_d;
         samples_q   <= samples_d;
         pend_data_q <= pend_data_d;
         pend_q      <= pend_d;
         drdy_q      <= drdy_d;
         int_q       <= drdy_q & int_ctrl_q[1];
      end
   end

   assign INT  = int_q;
   // MISO is released whenever the synchronized select is high.
   assign MISO = ss_s ? 1'bz : tx_q[15];

endmodule
